// File: rtl/stopwatch_lap.sv
// Debounced two-button stopwatch with lap freeze; BCD count with 7-segment decode.
// Keys reach the FSM 2 sync + DEBOUNCE_CYCLES + 1 cycles after settling; bcd lags its source by one cycle.
module stopwatch_lap #(
  parameter int CLK_HZ          = 50000000,
  parameter int TICK_HZ         = 100,
  parameter int DIGITS          = 6,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_start,
  input  logic                  key_lap,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  running,
  output logic                  lap_active,
  output logic                  overflow
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

  logic [1:0] keys;
  logic [1:0] press;
  logic       start_press;
  logic       lap_press;

  assign keys        = {key_lap, key_start};
  assign start_press = press[0];
  assign lap_press   = press[1];

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic          s1, s2, acc, prs;
    logic [DW-1:0] cnt;

    // cnt counts consecutive synchronised samples that disagree with the accepted level
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1  <= 1'b1;
        s2  <= 1'b1;
        acc <= 1'b1;
        prs <= 1'b0;
        cnt <= '0;
      end else begin
        s1  <= keys[k];
        s2  <= s1;
        prs <= 1'b0;
        if (s2 == acc) begin
          cnt <= '0;
        end else if (cnt == DEB_LAST) begin
          acc <= s2;
          cnt <= '0;
          prs <= ~s2;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end
    end

    assign press[k] = prs;
  end

  state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // start always wins over a coincident lap press
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_press) state_d = RUN;
      RUN:  if (start_press) state_d = STOP; else if (lap_press) state_d = LAP;
      LAP:  if (start_press) state_d = STOP; else if (lap_press) state_d = RUN;
      STOP: if (start_press) state_d = RUN;  else if (lap_press) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    running    = (state_q == RUN) || (state_q == LAP);
    lap_active = (state_q == LAP);
  end

  logic [PW-1:0]       pre_q;
  logic [4*DIGITS-1:0] live_q, lap_q, live_inc;
  logic                tick, wrap, carry, clr;

  assign tick = running && (pre_q == PRE_MAX);
  assign clr  = (state_d == IDLE);

  always_comb begin
    live_inc = live_q;
    carry    = tick;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (live_q[4*i +: 4] == 4'd9) begin
          live_inc[4*i +: 4] = 4'd0;
        end else begin
          live_inc[4*i +: 4] = live_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q    <= '0;
      live_q   <= '0;
      lap_q    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      pre_q    <= '0;
      live_q   <= '0;
      lap_q    <= '0;
      overflow <= 1'b0;
    end else begin
      if (running) pre_q <= tick ? '0 : pre_q + PW'(1);
      if (tick)    live_q <= live_inc;
      if (wrap)    overflow <= 1'b1;
      if (state_q == RUN && lap_press && !start_press) lap_q <= live_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bcd <= '0;
    else     bcd <= (state_q == LAP) ? lap_q : live_q;
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    assign seg[7*i +: 7] = seg7(bcd[4*i +: 4]);
  end

endmodule

// File: tb/tb_stopwatch_lap.sv
// Stopwatch bench: integer-count reference model stepped once per clock, randomized and directed key scenarios.
module tb_stopwatch_lap;
  localparam int DIGITS = 2;
  localparam int DIV    = 10;
  localparam int DEB    = 4;
  localparam int MODV   = 100;

  logic clk = 1'b0;
  logic rst, key_start, key_lap;
  logic [4*DIGITS-1:0] bcd;
  logic [7*DIGITS-1:0] seg;
  logic running, lap_active, overflow;

  int n_chk = 0;
  int n_fail = 0;

  stopwatch_lap #(.CLK_HZ(1000), .TICK_HZ(100), .DIGITS(DIGITS), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .key_start(key_start), .key_lap(key_lap),
    .bcd(bcd), .seg(seg), .running(running), .lap_active(lap_active), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // model: 0 idle, 1 run, 2 lap, 3 stop; counts kept as plain integers
  int m_s1[2], m_s2[2], m_acc[2], m_run[2], m_prs[2];
  int m_st, m_live, m_lap, m_pre, m_disp;
  bit m_ovf;
  int m_sp_cnt = 0;
  int dut_sp_cnt = 0;

  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 1; m_s2[k] = 1; m_acc[k] = 1; m_run[k] = 0; m_prs[k] = 0;
    end
    m_st = 0; m_live = 0; m_lap = 0; m_pre = 0; m_disp = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input bit ks, input bit kl, input bit r);
    int sp, lp, st_n, inkey[2];
    bit act;
    if (r) begin
      model_reset();
      return;
    end
    sp = m_prs[0]; lp = m_prs[1];
    inkey[0] = ks; inkey[1] = kl;
    for (int k = 0; k < 2; k++) begin
      int synced, np;
      synced = m_s2[k]; np = 0;
      if (synced != m_acc[k]) begin
        m_run[k]++;
        if (m_run[k] == DEB) begin
          m_acc[k] = synced; m_run[k] = 0; np = (synced == 0);
        end
      end else m_run[k] = 0;
      m_s2[k] = m_s1[k]; m_s1[k] = inkey[k]; m_prs[k] = np;
      if (k == 0 && np) m_sp_cnt++;
    end
    st_n = m_st;
    if (sp) st_n = (m_st == 1 || m_st == 2) ? 3 : 1;
    else if (lp) st_n = (m_st == 1) ? 2 : (m_st == 2) ? 1 : (m_st == 3) ? 0 : m_st;
    act = (m_st == 1 || m_st == 2);
    m_disp = (m_st == 2) ? m_lap : m_live;
    if (st_n == 0) begin
      m_live = 0; m_lap = 0; m_pre = 0; m_ovf = 0;
    end else begin
      if (m_st == 1 && lp && !sp) m_lap = m_live;
      if (act) begin
        if (m_pre == DIV - 1) begin
          if (m_live == MODV - 1) m_ovf = 1;
          m_live = (m_live + 1) % MODV;
          m_pre = 0;
        end else m_pre++;
      end
    end
    m_st = st_n;
  endtask

  function automatic logic [4*DIGITS-1:0] bcd_of(input int v);
    logic [4*DIGITS-1:0] b;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  function automatic logic [4*DIGITS+2:0] exp_vec();
    return {bcd_of(m_disp), m_st == 1 || m_st == 2, m_st == 2, m_ovf};
  endfunction

  function automatic logic [7*DIGITS-1:0] exp_seg();
    logic [7*DIGITS-1:0] s;
    int v = m_disp;
    for (int i = 0; i < DIGITS; i++) begin
      s[7*i +: 7] = segtab[v % 10];
      v = v / 10;
    end
    return s;
  endfunction

  task automatic step();
    bit ks, kl, r;
    ks = key_start; kl = key_lap; r = rst;
    @(posedge clk);
    model_edge(ks, kl, r);
    #1;
    if (dut.start_press === 1'b1) dut_sp_cnt++;
  endtask

  task automatic pulse_reset();
    rst = 1; key_start = 1; key_lap = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; key_start = 1; key_lap = 1;
    model_reset();
    step(); step();
    n_chk++;
    if ({bcd, running, lap_active, overflow} !== exp_vec() || bcd !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h exp %h", {bcd, running, lap_active, overflow}, exp_vec());
    end
    n_chk++;
    if (seg !== {DIGITS{7'b1000000}}) begin
      n_fail++; $display("FAIL reset_seg: got %h exp %h", seg, {DIGITS{7'b1000000}});
    end
    rst = 0;
  endtask

  task automatic test_start();
    int t_run = -1;
    int sp0 = dut_sp_cnt;
    for (int i = 0; i < 140; i++) begin
      key_start = (i < 10) ? 1'b0 : 1'b1;
      step();
      n_chk++;
      if ({bcd, running, lap_active, overflow} !== exp_vec()) begin
        n_fail++; $display("FAIL start_cycle%0d: got %h exp %h", i, {bcd, running, lap_active, overflow}, exp_vec());
      end
      if (running === 1'b1 && t_run < 0) t_run = i;
      if (t_run >= 0 && i == t_run + 101) begin
        n_chk++;
        if (bcd !== 8'h10) begin n_fail++; $display("FAIL start_ten_ticks: got %h exp 10", bcd); end
      end
    end
    n_chk++;
    if (t_run < 0 || dut_sp_cnt - sp0 != 1) begin
      n_fail++; $display("FAIL start_pulse: rise at %0d pulses %0d exp 1", t_run, dut_sp_cnt - sp0);
    end
  endtask

  task automatic test_bounce();
    int sp0 = dut_sp_cnt;
    int msp0 = m_sp_cnt;
    for (int i = 0; i < 44; i++) begin
      key_start = (i < 20) ? (((i / 3) % 2) != 0) : (i >= 32);
      step();
      n_chk++;
      if ({bcd, running, lap_active, overflow} !== exp_vec()) begin
        n_fail++; $display("FAIL bounce_cycle%0d: got %h exp %h", i, {bcd, running, lap_active, overflow}, exp_vec());
      end
    end
    n_chk++;
    if (dut_sp_cnt - sp0 != 1 || m_sp_cnt - msp0 != 1 || running !== 1'b0) begin
      n_fail++; $display("FAIL bounce_single: pulses %0d running %b exp 1 pulse running 0", dut_sp_cnt - sp0, running);
    end
  endtask

  task automatic test_lap();
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      key_start = (i < 8) ? 1'b0 : 1'b1;
      step();
      n_chk++;
      if ({bcd, running, lap_active, overflow} !== exp_vec()) begin
        n_fail++; $display("FAIL lap_wait%0d: got %h exp %h", i, {bcd, running, lap_active, overflow}, exp_vec());
      end
      if (bcd == 8'h25) break;
    end
    n_chk++;
    if (bcd !== 8'h25) begin n_fail++; $display("FAIL lap_reach25: got %h exp 25", bcd); end
    for (int i = 0; i < 48; i++) begin
      key_lap = (i < 8) ? 1'b0 : 1'b1;
      step();
      n_chk++;
      if ({bcd, running, lap_active, overflow} !== exp_vec()) begin
        n_fail++; $display("FAIL lap_hold%0d: got %h exp %h", i, {bcd, running, lap_active, overflow}, exp_vec());
      end
    end
    n_chk++;
    if (lap_active !== 1'b1 || bcd !== 8'h25 || m_live <= 25) begin
      n_fail++; $display("FAIL lap_frozen: lap_active %b bcd %h exp 1 25", lap_active, bcd);
    end
    for (int i = 0; i < 18; i++) begin
      key_lap = (i < 8) ? 1'b0 : 1'b1;
      step();
      n_chk++;
      if ({bcd, running, lap_active, overflow} !== exp_vec()) begin
        n_fail++; $display("FAIL lap_release%0d: got %h exp %h", i, {bcd, running, lap_active, overflow}, exp_vec());
      end
    end
    n_chk++;
    if (lap_active !== 1'b0 || running !== 1'b1 || bcd !== bcd_of(m_disp) || bcd == 8'h25) begin
      n_fail++; $display("FAIL lap_live: lap_active %b bcd %h exp 0 %h", lap_active, bcd, bcd_of(m_disp));
    end
  endtask

  task automatic test_overflow();
    bit seen99 = 0;
    pulse_reset();
    for (int i = 0; i < 1100; i++) begin
      key_start = (i < 8) ? 1'b0 : 1'b1;
      step();
      if (bcd == 8'h98) break;
    end
    n_chk++;
    if (bcd !== 8'h98 || {bcd, running, lap_active, overflow} !== exp_vec()) begin
      n_fail++; $display("FAIL ovf_reach98: got %h exp 98", bcd);
    end
    for (int i = 0; i < 25; i++) begin
      step();
      if (bcd == 8'h99) seen99 = 1;
      if (bcd == 8'h00) break;
    end
    n_chk++;
    if (!seen99 || bcd !== 8'h00 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_wrap: seen99 %b bcd %h ovf %b exp 1 00 1", seen99, bcd, overflow);
    end
    for (int i = 0; i < 30; i++) step();
    n_chk++;
    if (overflow !== 1'b1 || {bcd, running, lap_active, overflow} !== exp_vec()) begin
      n_fail++; $display("FAIL ovf_sticky: ovf %b bcd %h exp 1 %h", overflow, bcd, bcd_of(m_disp));
    end
    for (int i = 0; i < 16; i++) begin key_start = (i < 8) ? 1'b0 : 1'b1; step(); end
    n_chk++;
    if (running !== 1'b0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_stop: running %b ovf %b exp 0 1", running, overflow);
    end
    for (int i = 0; i < 16; i++) begin key_lap = (i < 8) ? 1'b0 : 1'b1; step(); end
    n_chk++;
    if (bcd !== 8'h00 || overflow !== 1'b0 || running !== 1'b0 || {bcd, running, lap_active, overflow} !== exp_vec()) begin
      n_fail++; $display("FAIL ovf_clear: bcd %h ovf %b exp 00 0", bcd, overflow);
    end
  endtask

  task automatic test_both();
    int saved_lap, hold_disp;
    pulse_reset();
    for (int i = 0; i < 60; i++) begin key_start = (i < 8) ? 1'b0 : 1'b1; step(); end
    for (int i = 0; i < 36; i++) begin key_lap = ((i % 18) < 8) ? 1'b0 : 1'b1; step(); end
    saved_lap = m_lap;
    for (int i = 0; i < 18; i++) begin
      key_start = (i < 8) ? 1'b0 : 1'b1;
      key_lap   = (i < 8) ? 1'b0 : 1'b1;
      step();
    end
    n_chk++;
    if (running !== 1'b0 || lap_active !== 1'b0 || dut.lap_q !== bcd_of(saved_lap) || saved_lap == 0) begin
      n_fail++; $display("FAIL both_stop: running %b lap_q %h exp 0 %h", running, dut.lap_q, bcd_of(saved_lap));
    end
    hold_disp = m_disp;
    for (int i = 0; i < 50; i++) begin
      step();
      n_chk++;
      if (bcd !== bcd_of(hold_disp) || dut.pre_q !== 4'(m_pre)) begin
        n_fail++; $display("FAIL both_hold%0d: bcd %h pre %0d exp %h %0d", i, bcd, dut.pre_q, bcd_of(hold_disp), m_pre);
      end
    end
    for (int i = 0; i < 40; i++) begin
      key_start = (i < 8) ? 1'b0 : 1'b1;
      step();
      n_chk++;
      if ({bcd, running, lap_active, overflow} !== exp_vec() || dut.pre_q !== 4'(m_pre)) begin
        n_fail++; $display("FAIL both_resume%0d: got %h pre %0d exp %h %0d", i, {bcd, running, lap_active, overflow}, dut.pre_q, exp_vec(), m_pre);
      end
    end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    for (int i = 0; i < 500; i++) begin
      key_start = (i < 8) ? 1'b0 : 1'b1;
      step();
      if (bcd == 8'h37) break;
    end
    n_chk++;
    if (bcd !== 8'h37 || running !== 1'b1) begin n_fail++; $display("FAIL arst_reach37: got %h exp 37", bcd); end
    #3 rst = 1;
    model_reset();
    #1;
    n_chk++;
    if ({bcd, running, lap_active, overflow} !== 11'h0 || seg !== {DIGITS{7'b1000000}}) begin
      n_fail++; $display("FAIL arst_immediate: got %h seg %h exp 0 %h", {bcd, running, lap_active, overflow}, seg, {DIGITS{7'b1000000}});
    end
    key_start = 0;
    step(); step();
    rst = 0;
    for (int i = 0; i < 12; i++) step();
    n_chk++;
    if (running !== 1'b1 || m_sp_cnt != dut_sp_cnt || {bcd, running, lap_active, overflow} !== exp_vec()) begin
      n_fail++; $display("FAIL arst_held_key: running %b pulses %0d exp 1 %0d", running, dut_sp_cnt, m_sp_cnt);
    end
    key_start = 1;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) key_start = ~key_start;
      if ($urandom_range(0, 5) == 0) key_lap = ~key_lap;
      rst = ($urandom_range(0, 499) == 0);
      step();
      n_chk++;
      if ({bcd, running, lap_active, overflow} !== exp_vec() || seg !== exp_seg()) begin
        n_fail++; $display("FAIL random%0d: got %h seg %h exp %h seg %h", i, {bcd, running, lap_active, overflow}, seg, exp_vec(), exp_seg());
      end
    end
    rst = 0;
    n_chk++;
    if (m_sp_cnt != dut_sp_cnt) begin
      n_fail++; $display("FAIL random_pulses: got %0d exp %0d", dut_sp_cnt, m_sp_cnt);
    end
  endtask

  initial begin
    rst = 1; key_start = 1; key_lap = 1;
    test_reset();
    test_start();
    test_bounce();
    test_lap();
    test_overflow();
    test_both();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stopwatch_lap.md
STOPWATCH_LAP -- requirements
Module: stopwatch_lap

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, count resolution in Hz; CLK_HZ/TICK_HZ is an integer >= 2.
REQ-003 SHALL have parameter DIGITS, default 6, number of BCD digits, range 1..8.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, clock cycles a key must be stable before its new level is accepted.
REQ-005 SHALL have port clk input 1, single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst input 1, asynchronous active-high reset.
REQ-007 SHALL have port key_start input 1, raw asynchronous push button, active-low; press toggles run/stop.
REQ-008 SHALL have port key_lap input 1, raw asynchronous push button, active-low; press is lap/clear.
REQ-009 SHALL have port bcd output 4*DIGITS, displayed value; digit 0 in [3:0] is least significant.
REQ-010 SHALL have port seg output 7*DIGITS, per-digit 7-segment pattern of bcd, active-low, bit order g..a, digit 0 in [6:0].
REQ-011 SHALL have port running output 1, high in RUN and LAP.
REQ-012 SHALL have port lap_active output 1, high in LAP (display frozen).
REQ-013 SHALL have port overflow output 1, sticky flag set on counter wrap.

Function
REQ-014 Each key SHALL pass through a 2-flop synchroniser, then a debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-015 Each debouncer SHALL emit a one-cycle press pulse on the accepted high-to-low transition only; release produces no pulse.
REQ-016 If both press pulses occur in the same cycle, the start pulse SHALL be acted on and the lap pulse discarded.
REQ-017 FSM SHALL have states IDLE, RUN, LAP, STOP.
REQ-018 IDLE: start -> RUN; lap ignored.
REQ-019 RUN: start -> STOP; lap -> LAP, capturing the live count into the lap register in the same edge.
REQ-020 LAP: lap -> RUN (display releases to live count); start -> STOP.
REQ-021 STOP: start -> RUN (count resumes from held value); lap -> IDLE (clear).
REQ-022 Prescaler SHALL count 0..CLK_HZ/TICK_HZ-1, advancing only in RUN and LAP, holding its value in STOP, and forced to 0 in IDLE.
REQ-023 Tick SHALL be the cycle prescaler equals CLK_HZ/TICK_HZ-1; the live count SHALL increment by 1 on that edge.
REQ-024 Live count SHALL be DIGITS-digit decimal BCD with ripple carry; every digit stays in 0..9.
REQ-025 Increment from all-9s SHALL wrap to all-0s and set overflow in the same edge; counting continues.
REQ-026 On entry to IDLE, live count, lap register, prescaler and overflow SHALL clear to 0.
REQ-027 bcd SHALL show the lap register in LAP and the live count otherwise, registered; it updates one cycle after the selected source changes.
REQ-028 seg SHALL be a combinational decode of bcd: 0..9 standard patterns, active-low; 0 = 7'b1000000.
REQ-029 running and lap_active SHALL be decoded from the registered state with no extra latency.

Reset
REQ-030 On rst high, asynchronously: state IDLE, live count 0, lap register 0, prescaler 0, debouncer accepted levels high (released), synchroniser flops high, bcd 0, seg all digits 7'b1000000, running 0, lap_active 0, overflow 0.
REQ-031 Reset asserted mid-count or mid-debounce SHALL abort immediately; a key held low through reset release SHALL produce one press pulse after DEBOUNCE_CYCLES.

Verification (CLK_HZ=1000, TICK_HZ=100, DIGITS=2, DEBOUNCE_CYCLES=4)
REQ-032 Reset then start press held 10 cycles -> one press pulse, running=1; after 10 ticks (100 clk) bcd=8'h10.
REQ-033 Start key bounce of 3-cycle pulses for 20 cycles then stable low -> exactly one press pulse, single state change.
REQ-034 RUN at bcd=8'h25, lap press -> lap_active=1, bcd held 8'h25 while live count advances; second lap -> bcd shows live value.
REQ-035 RUN from 8'h98, two ticks -> bcd 8'h99 then 8'h00, overflow=1 and stays 1; STOP then lap -> IDLE, bcd=0, overflow=0.
REQ-036 Start and lap pulses same cycle in RUN -> STOP entered, lap register unchanged; STOP held 50 cycles -> bcd constant, prescaler resumes from held value on restart.
REQ-037 rst asserted while RUN at 8'h37 -> all outputs reach reset values without a clock edge.
